keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner. It drives one-hot column strobes from a clock-enable divider, which means no derived clock. It samples the row inputs, debounces whole scan frames and reports a single encoded keypress with a one-cycle valid pulse. The block sits between the keypad pins and the game-control logic and replaces the free-running 4x4 column rotator.

---
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: matrix-keypad column scanner with frame debouncing.
// Drives one-hot column strobes from a clock-enable divider, samples the
// synchronised rows into a per-column frame buffer, classifies each full
// frame as NONE / SINGLE / MULTI and commits changes after DEBOUNCE
// identical frames. A new single key is reported with a one-cycle pulse.
module keypad_scanner #(
    parameter int unsigned  ROWS     = 4,
    parameter int unsigned  COLS     = 4,
    parameter int unsigned  SCAN_DIV = 100000,
    parameter int unsigned  DEBOUNCE = 4,
    localparam int unsigned CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   row,
    output logic [COLS-1:0]   column,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_down,
    output logic              multi_key
);

    localparam int unsigned NKEYS = ROWS * COLS;
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_e;
    typedef enum logic [1:0] {IDLE, PRESSED, MULTI} state_e;

    logic [ROWS-1:0]   row_meta_q, row_sync_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [COLS-1:0]   column_q;
    logic [NKEYS-1:0]  frame_q, frame_d;
    cls_e              prev_cls_q, cand_cls;
    logic [CODE_W-1:0] prev_code_q, cand_code, hit;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        ones;
    logic              tick, frame_end, commit;
    state_e            state_q;
    logic [CODE_W-1:0] key_code_q;
    logic              key_valid_q, key_down_q, multi_key_q;

    // Two-flop synchroniser for the asynchronous row pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '0;
            row_sync_q <= '0;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Divider, column index and frame buffer next-state (buffer includes the current sample).
    always_comb begin
        tick      = (div_q == DIV_W'(SCAN_DIV - 1));
        frame_end = tick && (col_q == COL_W'(COLS - 1));
        div_d     = tick ? '0 : div_q + 1'b1;
        col_d     = col_q;
        frame_d   = frame_q;
        if (tick) begin
            frame_d[int'(col_q) * ROWS +: ROWS] = row_sync_q;
            col_d = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + 1'b1;
        end
    end

    // Scan timing state: divider, column index, one-hot strobe, frame buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            col_q    <= '0;
            column_q <= COLS'(1);
            frame_q  <= '0;
        end else begin
            div_q   <= div_d;
            col_q   <= col_d;
            frame_q <= frame_d;
            if (tick) begin
                column_q        <= '0;
                column_q[col_d] <= 1'b1;
            end
        end
    end

    // Frame classification and debounce counter next-state.
    always_comb begin
        ones = 2'd0;
        hit  = '0;
        for (int unsigned i = 0; i < NKEYS; i++) begin
            if (frame_d[i]) begin
                hit = CODE_W'(i);
                if (ones != 2'd2) ones = ones + 2'd1;
            end
        end
        case (ones)
            2'd0:    cand_cls = CLS_NONE;
            2'd1:    cand_cls = CLS_SINGLE;
            default: cand_cls = CLS_MULTI;
        endcase
        // Code only distinguishes SINGLE candidates; NONE/MULTI compare on class alone.
        cand_code = (ones == 2'd1) ? hit : '0;
        if (cand_cls == prev_cls_q && cand_code == prev_code_q)
            cnt_d = (cnt_q == CNT_W'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1;
        else
            cnt_d = CNT_W'(1);
        // Commits repeat every saturated frame; the FSM makes repeats no-ops.
        commit = (cnt_d == CNT_W'(DEBOUNCE));
    end

    // Debounce history: previous frame candidate and stable-frame count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_cls_q  <= CLS_NONE;
            prev_code_q <= '0;
            cnt_q       <= '0;
        end else if (frame_end) begin
            prev_cls_q  <= cand_cls;
            prev_code_q <= cand_code;
            cnt_q       <= cnt_d;
        end
    end

    // Key state machine with registered outputs, advancing only on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (frame_end && commit) begin
                case (cand_cls)
                    CLS_NONE: begin
                        state_q     <= IDLE;
                        key_down_q  <= 1'b0;
                        multi_key_q <= 1'b0;
                    end
                    CLS_SINGLE: begin
                        if (!(state_q == PRESSED && key_code_q == cand_code)) begin
                            state_q     <= PRESSED;
                            key_code_q  <= cand_code;
                            key_down_q  <= 1'b1;
                            multi_key_q <= 1'b0;
                            key_valid_q <= 1'b1;
                        end
                    end
                    CLS_MULTI: begin
                        state_q     <= MULTI;
                        key_down_q  <= 1'b0;
                        multi_key_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign column    = column_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a cycle-indexed keypad model predicts every
// output on each cycle, plus directed scenarios with literal expectations.
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 2;
    localparam int FRAME    = COLS * SCAN_DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  column;
    logic [3:0]  key_code;
    logic        key_valid, key_down, multi_key;
    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .row(row), .column(column),
        .key_code(key_code), .key_valid(key_valid),
        .key_down(key_down), .multi_key(multi_key)
    );

    // Physical keypad: a row reads high when a pressed key sits on a driven column.
    always_comb begin
        row = '0;
        for (int c = 0; c < COLS; c++)
            if (column[c]) row = row | pressed[c*ROWS +: ROWS];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge k after reset release; column c is sampled at the
    // last edge of its dwell using the keypad state from two edges earlier.
    int unsigned k = 0;
    logic [15:0] d1 = '0, d2 = '0, fb = '0;
    int prev_cls = 0, prev_code = 0, cnt = 0, st = 0;
    logic [3:0] m_col = 4'b0001, m_code = '0;
    logic m_valid = 0, m_down = 0, m_multi = 0;

    initial begin
        int c, n, cls, code;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0; d1 = '0; d2 = '0; fb = '0;
                prev_cls = 0; prev_code = 0; cnt = 0; st = 0;
                m_col = 4'b0001; m_code = '0;
                m_valid = 0; m_down = 0; m_multi = 0;
            end else begin
                m_valid = 0;
                if (k % SCAN_DIV == SCAN_DIV - 1) begin
                    c = int'((k / SCAN_DIV) % COLS);
                    for (int r = 0; r < ROWS; r++) fb[c*ROWS + r] = d2[c*ROWS + r];
                    if (c == COLS - 1) begin
                        n    = $countones(fb);
                        cls  = (n == 0) ? 0 : (n == 1) ? 1 : 2;
                        code = 0;
                        if (n == 1)
                            for (int i = 0; i < 16; i++) if (fb[i]) code = i;
                        if (cls == prev_cls && code == prev_code)
                            cnt = (cnt < DEBOUNCE) ? cnt + 1 : cnt;
                        else
                            cnt = 1;
                        prev_cls  = cls;
                        prev_code = code;
                        if (cnt == DEBOUNCE) begin
                            if (cls == 0) begin
                                st = 0; m_down = 0; m_multi = 0;
                            end else if (cls == 2) begin
                                st = 2; m_down = 0; m_multi = 1;
                            end else if (!(st == 1 && int'(m_code) == code)) begin
                                st = 1; m_code = 4'(code); m_down = 1; m_multi = 0; m_valid = 1;
                            end
                        end
                    end
                    m_col = 4'b0001 << ((c + 1) % COLS);
                end
                d2 = d1;
                d1 = pressed;
                k++;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("column",    int'(column),    int'(m_col));
            chk("key_code",  int'(key_code),  int'(m_code));
            chk("key_valid", int'(key_valid), int'(m_valid));
            chk("key_down",  int'(key_down),  int'(m_down));
            chk("multi_key", int'(multi_key), int'(m_multi));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (key_valid) pulses++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    logic [3:0] rot_tab [16] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd4,
                                 4'd4, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8, 4'd8, 4'd1};

    initial begin
        int base;
        pressed = '0;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Column rotation right after release.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            #1 chk("rotation", int'(column), int'(rot_tab[i]));
        end
        wait_cyc(2 * FRAME);
        chk("idle_valid", int'(key_valid), 0);
        chk("idle_down",  int'(key_down),  0);
        chk("idle_multi", int'(multi_key), 0);
        chk("idle_code",  int'(key_code),  0);
        chk("idle_pulses", pulses, 0);

        // Single press: column 2, row 1 -> code 9.
        base = pulses;
        pressed[9] = 1'b1;
        wait_cyc(4 * FRAME);
        chk("press_pulses", pulses - base, 1);
        chk("press_code",   int'(key_code), 9);
        chk("press_down",   int'(key_down), 1);
        wait_cyc(3 * FRAME);
        chk("held_pulses",  pulses - base, 1);

        // Release.
        base = pulses;
        pressed = '0;
        wait_cyc(3 * FRAME + 4);
        chk("rel_down",   int'(key_down), 0);
        chk("rel_pulses", pulses - base, 0);
        chk("rel_code",   int'(key_code), 9);

        // Bounce: key 7 on alternate frames.
        base = pulses;
        for (int i = 0; i < 8; i++) begin
            pressed[7] = ~pressed[7];
            wait_cyc(FRAME);
        end
        chk("bounce_pulses", pulses - base, 0);
        chk("bounce_down",   int'(key_down), 0);
        pressed = '0;
        wait_cyc(3 * FRAME);

        // Multi then rollover.
        base = pulses;
        pressed[5]  = 1'b1;
        pressed[10] = 1'b1;
        wait_cyc(4 * FRAME);
        chk("multi_multi",  int'(multi_key), 1);
        chk("multi_down",   int'(key_down), 0);
        chk("multi_pulses", pulses - base, 0);
        chk("multi_code",   int'(key_code), 9);
        pressed[10] = 1'b0;
        wait_cyc(4 * FRAME);
        chk("roll_pulses", pulses - base, 1);
        chk("roll_code",   int'(key_code), 5);
        chk("roll_multi",  int'(multi_key), 0);
        chk("roll_down",   int'(key_down), 1);

        // Asynchronous reset mid-frame with key 5 still held.
        wait_cyc(5);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_column", int'(column),    1);
        chk("rst_code",   int'(key_code),  0);
        chk("rst_valid",  int'(key_valid), 0);
        chk("rst_down",   int'(key_down),  0);
        chk("rst_multi",  int'(multi_key), 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        base = pulses;
        wait_cyc(20);
        chk("rerun_early", pulses - base, 0);
        wait_cyc(16);
        chk("rerun_pulses", pulses - base, 1);
        chk("rerun_code",   int'(key_code), 5);
        chk("rerun_down",   int'(key_down), 1);

        pressed = '0;
        wait_cyc(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
